// File: rtl/lsu_riscv_if.sv
// Core/memory bundle for the RISC-V load/store unit; the LSU connects through the slave modport,
// and the core/memory side (or a testbench) through the master modport.
interface lsu_riscv_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        core_misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_req_o, core_misalign_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_req_o, core_misalign_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_riscv.sv
// RISC-V load/store unit: IDLE/WAIT/DONE handshake, byte lanes, load extension.
// Optional macro LSU_MISALIGN_CHECK_EN traps misaligned H/W accesses instead of issuing them.
module lsu_riscv (
  input  logic        clk_i,
  input  logic        arst_n_i,
  lsu_riscv_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rd_q, rd_d;
  logic        misalign_q, misalign_d;

  logic        reqIsByte, reqIsHalf, reqMisalign;
  logic [3:0]  reqBe;
  logic [31:0] reqWd;

  // Size codes other than B/BU (x00) and H/HU (x01) all behave as a word.
  assign reqIsByte = (bus.core_size_i[1:0] == 2'b00);
  assign reqIsHalf = (bus.core_size_i[1:0] == 2'b01);

  always_comb begin
    reqBe = 4'b1111;
    reqWd = bus.core_wd_i;
    if (reqIsByte) begin
      reqBe = 4'b0001 << bus.core_addr_i[1:0];
      reqWd = {4{bus.core_wd_i[7:0]}};
    end else if (reqIsHalf) begin
      reqBe = 4'b0011 << {bus.core_addr_i[1], 1'b0};
      reqWd = {2{bus.core_wd_i[15:0]}};
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign reqMisalign = (reqIsHalf && bus.core_addr_i[0]) ||
                       (!reqIsByte && !reqIsHalf && (bus.core_addr_i[1:0] != 2'b00));
`else
  assign reqMisalign = 1'b0;
`endif

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadVal;

  assign loadByte = bus.mem_rd_i[{off_q, 3'b000} +: 8];
  assign loadHalf = off_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];

  always_comb begin
    loadVal = bus.mem_rd_i;
    if (size_q[1:0] == 2'b00) begin
      loadVal = size_q[2] ? {24'b0, loadByte} : {{24{loadByte[7]}}, loadByte};
    end else if (size_q[1:0] == 2'b01) begin
      loadVal = size_q[2] ? {16'b0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    off_d      = off_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    be_d       = be_q;
    rd_d       = rd_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.core_req_i) begin
          if (reqMisalign) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = WAIT;
            we_d    = bus.core_we_i;
            size_d  = bus.core_size_i;
            off_d   = bus.core_addr_i[1:0];
            addr_d  = {bus.core_addr_i[31:2], 2'b00};
            wd_d    = reqWd;
            be_d    = reqBe;
          end
        end
      end
      WAIT: begin
        if (bus.mem_ready_i) begin
          state_d = DONE;
          if (!we_q) begin
            rd_d = loadVal;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset clears the bus-facing registers so an abandoned WAIT leaves nothing on the bus.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      off_q      <= 2'd0;
      addr_q     <= 32'd0;
      wd_q       <= 32'd0;
      be_q       <= 4'd0;
      rd_q       <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.mem_req_o        = (state_q == WAIT);
  assign bus.mem_we_o         = we_q;
  assign bus.mem_be_o         = be_q;
  assign bus.mem_addr_o       = addr_q;
  assign bus.mem_wd_o         = wd_q;
  assign bus.core_rd_o        = rd_q;
  assign bus.core_misalign_o  = misalign_q;
  assign bus.core_stall_req_o = bus.core_req_i && (state_q != DONE);

endmodule

// File: doc/lsu_riscv.md
LSU_RISCV -- requirements
Module: lsu_riscv

Interface
REQ-001 The block SHALL have these ports; clock and reset first.
- clk_i  in  1  system clock; all state updates on its rising edge
- arst_n_i  in  1  asynchronous active-low reset
- core_req_i  in  1  memory instruction present (decoder mem_req)
- core_we_i  in  1  1 = store, 0 = load (decoder mem_we)
- core_size_i  in  3  access size (decoder mem_size): B=0, H=1, W=2, BU=4, HU=5
- core_addr_i  in  32  byte address (ALU result)
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  extended load data
- core_stall_req_o  out  1  stall the pipeline
- core_misalign_o  out  1  misaligned-access pulse
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address
- mem_wd_o  out  32  write data
- mem_rd_i  in  32  read data, valid with mem_ready_i
- mem_ready_i  in  1  memory accepts/completes the request
REQ-002 One clock; reset is asynchronous and active-low.

Function
REQ-003 The FSM SHALL have three states, IDLE, WAIT and DONE, with reset state IDLE.
REQ-004 IDLE -> WAIT when core_req_i=1, latching we, size, addr and wd into request registers.
REQ-005 In WAIT, mem_req_o SHALL be 1 and all mem_* outputs SHALL stay stable until mem_ready_i=1, then the FSM goes to DONE.
REQ-006 DONE -> IDLE unconditionally after one cycle.
REQ-007 mem_req_o SHALL be 1 only in WAIT.
REQ-008 core_stall_req_o SHALL equal core_req_i AND (state != DONE).
- Minimum latency: 3 cycles with stall in cycles 0-1, when mem_ready_i=1 in the first WAIT cycle.
REQ-009 mem_addr_o SHALL be {addr[31:2], 2'b00}.
REQ-010 mem_be_o SHALL be:
- B/BU: 4'b0001 << addr[1:0]
- H/HU: 4'b0011 << {addr[1], 1'b0}
- W: 4'b1111
REQ-011 mem_wd_o SHALL be:
- B/BU: {4{wd[7:0]}}
- H/HU: {2{wd[15:0]}}
- W: wd
REQ-012 Size codes 3, 6 and 7 SHALL be treated as W.
REQ-013 On a load completion (WAIT with mem_ready_i=1), the selected byte or halfword of mem_rd_i SHALL be registered, with sign extension for B/H and zero extension for BU/HU.
REQ-014 core_rd_o SHALL hold the last loaded value until the next load completes, and stores SHALL leave it unchanged.
REQ-015 If core_req_i drops in WAIT, the transaction SHALL still complete (a request is never withdrawn).
REQ-016 A new core_req_i in DONE SHALL be ignored, and a still-high core_req_i is sampled again in IDLE the next cycle (a back-to-back instruction issues a new access).

Reset
REQ-017 On arst_n_i=0, immediately and independent of clk_i:
- state = IDLE
- mem_req_o = 0, mem_we_o = 0, mem_be_o = 0, mem_addr_o = 0, mem_wd_o = 0
- core_rd_o = 0, core_misalign_o = 0
REQ-018 Reset during WAIT SHALL abandon the request, and mem_ready_i SHALL be ignored until a new WAIT.

Configuration
REQ-019 Macro LSU_MISALIGN_CHECK_EN defined:
- In IDLE, a request is misaligned if it is H/HU with addr[0]=1, or W with addr[1:0]!=0.
- A misaligned request SHALL go directly to DONE with no mem_req_o.
- core_misalign_o SHALL be 1 for that DONE cycle.
- core_rd_o SHALL be unchanged.
REQ-020 Macro LSU_MISALIGN_CHECK_EN undefined:
- core_misalign_o SHALL be tied 0.
- Misaligned requests SHALL proceed, with addr[0] ignored for H/HU and addr[1:0] ignored for W when forming mem_be_o and selecting load data.

Verification
REQ-021 Load sign-extended byte, no wait states: core_size_i=B, core_addr_i=0x1003, mem_rd_i=0x80AABBCC, mem_ready_i=1 -> mem_addr_o=0x1000, mem_be_o=0001<<3=1000, core_rd_o=0xFFFFFF80, stall high for 2 cycles.
REQ-022 Store halfword: core_size_i=H, core_addr_i=0x2002, core_wd_i=0x1234ABCD -> mem_we_o=1, mem_be_o=1100, mem_wd_o=0xABCDABCD, core_rd_o unchanged.
REQ-023 Wait states: LW at 0x10 with mem_ready_i low for 3 cycles -> mem_req_o and mem_* stable for 4 cycles, stall high for 5 cycles, then core_rd_o=mem_rd_i.
REQ-024 Zero-extended halfword plus mid-WAIT reset: LHU at 0x6, mem_rd_i=0xF00D0000 -> core_rd_o=0x0000F00D; repeat with arst_n_i pulsed low in WAIT -> mem_req_o=0 immediately, state IDLE, core_rd_o=0.
REQ-025 Misaligned word: LW at 0x5 with LSU_MISALIGN_CHECK_EN -> no mem_req_o and core_misalign_o=1 for one cycle; without the macro -> mem_be_o=1111, mem_addr_o=0x4, core_misalign_o=0.
